// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b definitions: disparity constants, well-known code-groups and
// the sub-block disparity rules used by the receive decoder.
package pcs_8b10b_pkg;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;
  localparam logic [9:0] D16_2_RDN = 10'h1B5;
  localparam logic [9:0] D16_2_RDP = 10'h245;

  typedef enum logic [1:0] {
    DISP_NEU = 2'd0,
    DISP_POS = 2'd1,
    DISP_NEG = 2'd2
  } disp_e;

  // 000111 and 111000 are balanced but still steer RD to a definite sign.
  function automatic disp_e disp6(input logic [5:0] sb);
    logic [2:0] ones;
    ones = '0;
    for (int i = 0; i < 6; i++) ones = ones + 3'(sb[i]);
    if (ones > 3'd3 || sb == 6'b000111) return DISP_POS;
    if (ones < 3'd3 || sb == 6'b111000) return DISP_NEG;
    return DISP_NEU;
  endfunction

  function automatic disp_e disp4(input logic [3:0] sb);
    logic [2:0] ones;
    ones = '0;
    for (int i = 0; i < 4; i++) ones = ones + 3'(sb[i]);
    if (ones > 3'd2 || sb == 4'b0011) return DISP_POS;
    if (ones < 3'd2 || sb == 4'b1100) return DISP_NEG;
    return DISP_NEU;
  endfunction

endpackage

// File: rtl/pcs_dec_6b5b.sv
// 6b -> 5b sub-block lookup (abcdei, a at bit 5), both RD columns accepted.
module pcs_dec_6b5b (
  input  logic [5:0] sb6,
  output logic [4:0] x,
  output logic       valid,
  output logic       is_k28
);

  always_comb begin
    x      = '0;
    valid  = 1'b1;
    is_k28 = 1'b0;
    unique case (sb6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      6'b001111, 6'b110000: begin
        x      = 5'd28;
        is_k28 = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pcs_decoder_10b8b.sv
// 1000BASE-X receive 10b/8b decoder: one-cycle registered decode with running
// disparity tracking, error flags and a saturating error counter.
module pcs_decoder_10b8b
  import pcs_8b10b_pkg::*;
#(
  parameter int   ERR_CNT_W = 8,
  parameter logic RD_INIT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cg_valid,
  input  logic [9:0]           code_group,
  input  logic                 err_clear,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic                 is_k,
  output logic                 comma,
  output logic                 code_err,
  output logic                 disp_err,
  output logic                 rd,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [4:0] x6;
  logic       v6, k28;
  logic [2:0] y3;
  logic       v4, is_a7;
  logic       dset, kset, grp_k, grp_ce, grp_de, grp_comma;
  logic       rd_mid, rd_new;
  disp_e      d6, d4;
  logic [ERR_CNT_W-1:0] cnt_base;

  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d, is_k_q, is_k_d, comma_q, comma_d;
  logic                 code_err_q, code_err_d, disp_err_q, disp_err_d;
  logic                 rd_q, rd_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  pcs_dec_6b5b u_dec_6b5b (
    .sb6    (code_group[9:4]),
    .x      (x6),
    .valid  (v6),
    .is_k28 (k28)
  );

  // 3b/4b lookup (fghj); A7 is tagged so its x can be qualified below.
  always_comb begin
    y3    = '0;
    v4    = 1'b1;
    is_a7 = 1'b0;
    case (code_group[3:0])
      4'b1011, 4'b0100: y3 = 3'd0;
      4'b1001:          y3 = 3'd1;
      4'b0101:          y3 = 3'd2;
      4'b1100, 4'b0011: y3 = 3'd3;
      4'b1101, 4'b0010: y3 = 3'd4;
      4'b1010:          y3 = 3'd5;
      4'b0110:          y3 = 3'd6;
      4'b1110, 4'b0001: y3 = 3'd7;
      4'b0111, 4'b1000: begin
        y3    = 3'd7;
        is_a7 = 1'b1;
      end
      default: v4 = 1'b0;
    endcase
  end

  always_comb begin
    dset      = x6 inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20};
    kset      = x6 inside {5'd23, 5'd27, 5'd28, 5'd29, 5'd30};
    grp_ce    = !v6 || !v4 || (is_a7 && !dset && !kset);
    grp_k     = k28 || (is_a7 && kset);
    grp_comma = (code_group[9:3] == 7'b0011111) || (code_group[9:3] == 7'b1100000);

    d6     = disp6(code_group[9:4]);
    d4     = disp4(code_group[3:0]);
    rd_mid = (d6 == DISP_NEU) ? rd_q : ((d6 == DISP_POS) ? RD_POS : RD_NEG);
    rd_new = (d4 == DISP_NEU) ? rd_mid : ((d4 == DISP_POS) ? RD_POS : RD_NEG);
    grp_de = ((d6 != DISP_NEU) && ((d6 == DISP_POS) == rd_q)) ||
             ((d4 != DISP_NEU) && ((d4 == DISP_POS) == rd_mid));
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = cg_valid;
    is_k_d     = is_k_q;
    comma_d    = comma_q;
    code_err_d = code_err_q;
    disp_err_d = disp_err_q;
    rd_d       = rd_q;
    if (cg_valid) begin
      data_d     = grp_ce ? 8'h00 : {y3, x6};
      is_k_d     = grp_k && !grp_ce;
      comma_d    = grp_comma;
      code_err_d = grp_ce;
      disp_err_d = grp_de;
      rd_d       = rd_new;
    end
    // Clear takes effect first so a same-cycle error leaves a count of one.
    cnt_base  = err_clear ? '0 : err_cnt_q;
    err_cnt_d = cnt_base;
    if (cg_valid && (grp_ce || grp_de) && (cnt_base != '1))
      err_cnt_d = cnt_base + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      is_k_q     <= 1'b0;
      comma_q    <= 1'b0;
      code_err_q <= 1'b0;
      disp_err_q <= 1'b0;
      rd_q       <= RD_INIT;
      err_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      is_k_q     <= is_k_d;
      comma_q    <= comma_d;
      code_err_q <= code_err_d;
      disp_err_q <= disp_err_d;
      rd_q       <= rd_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign is_k       = is_k_q;
  assign comma      = comma_q;
  assign code_err   = code_err_q;
  assign disp_err   = disp_err_q;
  assign rd         = rd_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pcs_decoder_10b8b.sv
// Scoreboard bench for pcs_decoder_10b8b: table-search reference model,
// directed test-plan sequences and randomized code-group traffic.
module tb_pcs_decoder_10b8b;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cg_valid = 1'b0;
  logic [9:0] code_group = '0;
  logic       err_clear = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, is_k, comma, code_err, disp_err, rd;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  pcs_decoder_10b8b #(.ERR_CNT_W(8), .RD_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .cg_valid   (cg_valid),
    .code_group (code_group),
    .err_clear  (err_clear),
    .data_out   (data_out),
    .data_valid (data_valid),
    .is_k       (is_k),
    .comma      (comma),
    .code_err   (code_err),
    .disp_err   (disp_err),
    .rd         (rd),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic [7:0] d;
    bit         k, cm, ce, de, rd;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;
  bit   m_rd = 1'b0;
  int   m_cnt = 0;

  logic [5:0] tab6_n [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] tab6_p [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] tab4_n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] tab4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // +1 positive, -1 negative, 0 neutral
  function automatic int sb_disp(input int ones, input int half, input bit pos_pat, input bit neg_pat);
    if (ones > half || pos_pat) return 1;
    if (ones < half || neg_pat) return -1;
    return 0;
  endfunction

  function automatic void ref_dec(input logic [9:0] cg, input bit rin,
                                  output logic [7:0] d, output bit k, output bit ce,
                                  output bit de, output bit rout);
    logic [5:0] s6;
    logic [3:0] s4;
    int x, y, r, d6, d4;
    bit a7, k28;
    s6 = cg[9:4];
    s4 = cg[3:0];
    x = -1;
    y = -1;
    for (int i = 0; i < 32; i++) if (tab6_n[i] == s6 || tab6_p[i] == s6) x = i;
    k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
    if (k28) x = 28;
    for (int i = 0; i < 8; i++) if (tab4_n[i] == s4 || tab4_p[i] == s4) y = i;
    a7 = (s4 == 4'b0111) || (s4 == 4'b1000);
    if (a7) y = 7;
    ce = (x < 0) || (y < 0) ||
         (a7 && !(x inside {11, 13, 14, 17, 18, 20, 23, 27, 28, 29, 30}));
    k  = !ce && (k28 || (a7 && (x inside {23, 27, 28, 29, 30})));
    d  = ce ? 8'h00 : 8'(y * 32 + x);
    d6 = sb_disp($countones(s6), 3, s6 == 6'b000111, s6 == 6'b111000);
    d4 = sb_disp($countones(s4), 2, s4 == 4'b0011, s4 == 4'b1100);
    r  = rin ? 1 : -1;
    de = 1'b0;
    if (d6 != 0) begin
      if (d6 == r) de = 1'b1;
      r = d6;
    end
    if (d4 != 0) begin
      if (d4 == r) de = 1'b1;
      r = d4;
    end
    rout = (r > 0);
  endfunction

  task automatic send(input logic [9:0] cg, input bit clr = 1'b0);
    exp_t e;
    logic [7:0] d;
    bit k, ce, de, rn;
    ref_dec(cg, m_rd, d, k, ce, de, rn);
    m_rd = rn;
    if (clr) m_cnt = 0;
    if ((ce || de) && m_cnt < 255) m_cnt++;
    e.d   = d;
    e.k   = k;
    e.ce  = ce;
    e.de  = de;
    e.rd  = rn;
    e.cm  = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    e.cnt = m_cnt;
    q.push_back(e);
    last = e;
    cg_valid   = 1'b1;
    code_group = cg;
    err_clear  = clr;
    @(posedge clk);
    #1;
    cg_valid  = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr = 1'b0);
    for (int i = 0; i < n; i++) begin
      cg_valid   = 1'b0;
      err_clear  = clr;
      code_group = 10'($urandom);
      if (clr) m_cnt = 0;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      chk("idle_valid", data_valid, 0);
      chk("idle_hold_data", data_out, last.d);
      chk("idle_hold_rd", rd, last.rd);
      chk("idle_cnt", err_cnt, m_cnt);
    end
  endtask

  // The group presented alongside reset is in flight and must be discarded.
  task automatic do_reset();
    reset      = 1'b1;
    cg_valid   = 1'b1;
    err_clear  = 1'b0;
    code_group = 10'($urandom);
    @(posedge clk);
    #1;
    cg_valid = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_is_k", is_k, 0);
    chk("rst_comma", comma, 0);
    chk("rst_code_err", code_err, 0);
    chk("rst_disp_err", disp_err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_rd", rd, 0);
    reset = 1'b0;
    m_rd  = 1'b0;
    m_cnt = 0;
    last  = '{d: 8'h00, k: 0, cm: 0, ce: 0, de: 0, rd: 0, cnt: 0};
  endtask

  task automatic send_rand_valid();
    int x, y, d6;
    bit mid;
    logic [5:0] s6;
    logic [3:0] s4;
    x  = $urandom_range(0, 31);
    y  = $urandom_range(0, 7);
    s6 = m_rd ? tab6_p[x] : tab6_n[x];
    d6 = sb_disp($countones(s6), 3, s6 == 6'b000111, s6 == 6'b111000);
    mid = (d6 == 0) ? m_rd : (d6 > 0);
    s4 = mid ? tab4_p[y] : tab4_n[y];
    if (y == 7 && $urandom_range(0, 1) == 1) s4 = mid ? 4'b1000 : 4'b0111;
    send({s6, s4});
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (data_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: data_valid=1 with data 0x%0h, expected no output", data_out);
      end else begin
        mon_e = q.pop_front();
        chk("sb_data", data_out, mon_e.d);
        chk("sb_is_k", is_k, mon_e.k);
        chk("sb_comma", comma, mon_e.cm);
        chk("sb_code_err", code_err, mon_e.ce);
        chk("sb_disp_err", disp_err, mon_e.de);
        chk("sb_rd", rd, mon_e.rd);
        chk("sb_err_cnt", err_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int r;
    bit rd_before;
    @(posedge clk);
    #1;
    do_reset();

    send(10'h0FA);
    chk("k285_data", data_out, 8'hBC);
    chk("k285_is_k", is_k, 1);
    chk("k285_comma", comma, 1);
    chk("k285_code_err", code_err, 0);
    chk("k285_disp_err", disp_err, 0);
    chk("k285_rd", rd, 1);
    send(10'h245);
    chk("d162_data", data_out, 8'h50);
    chk("d162_is_k", is_k, 0);
    chk("d162_rd", rd, 0);
    for (int i = 0; i < 100; i++) begin
      send(10'h0FA);
      send(10'h245);
    end
    chk("idle_stream_cnt", err_cnt, 0);
    chk("idle_stream_rd", rd, 0);

    send(10'h0FA);
    send(10'h0FA);
    chk("dup_k285_disp_err", disp_err, 1);
    chk("dup_k285_data", data_out, 8'hBC);
    chk("dup_k285_cnt", err_cnt, 1);

    send(10'h000);
    chk("bad_code_err", code_err, 1);
    chk("bad_data", data_out, 8'h00);
    chk("bad_is_k", is_k, 0);
    chk("bad_cnt", err_cnt, 2);
    send(10'h000, 1'b1);
    chk("clear_and_err_cnt", err_cnt, 1);

    rd_before = rd;
    send(10'h2AA);
    chk("d215_data", data_out, 8'hB5);
    chk("d215_rd", rd, rd_before);
    chk("d215_code_err", code_err, 0);
    idle(3);

    for (int i = 0; i < 260; i++) send(10'h000);
    chk("sat_cnt", err_cnt, 255);
    idle(1, 1'b1);
    chk("idle_clear_cnt", err_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) send_rand_valid();
      else if (r < 8) send(10'($urandom), $urandom_range(0, 15) == 0);
      else idle(1, $urandom_range(0, 7) == 0);
    end

    send(10'h0FA);
    send(10'h000);
    do_reset();
    for (int i = 0; i < 50; i++) send_rand_valid();

    idle(2);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
